// File: rtl/fixed_point_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fixed_point_mul_arbiter
// Brief    : Round-robin sharing of one fixed-point multiplier among NUM_REQ
//            lanes, with tag-tracked routing of results and overflow flags.
// Revision : 1.0
// ============================================================================
module fixed_point_mul_arbiter #(
    parameter int WIDTH       = 8,
    parameter int FRAC_BITS   = 3,
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 1,
    parameter int IDW         = $clog2(NUM_REQ)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       ENABLE,
    input  logic [NUM_REQ-1:0]         REQ_VALID,
    input  logic [NUM_REQ*WIDTH-1:0]   REQ_A,
    input  logic [NUM_REQ*WIDTH-1:0]   REQ_B,
    output logic [NUM_REQ-1:0]         REQ_READY,
    output logic [WIDTH-1:0]           MUL_A,
    output logic [WIDTH-1:0]           MUL_B,
    output logic                       MUL_VALID,
    input  logic [WIDTH-1:0]           MUL_RESULT,
    input  logic                       MUL_RESULT_VALID,
    output logic [NUM_REQ-1:0]         RSP_VALID,
    output logic [WIDTH-1:0]           RSP_DATA,
    output logic                       RSP_OVERFLOW,
    output logic                       IDLE
);

    localparam int c_CNT_W     = $clog2(MUL_LATENCY + 3);
    localparam bit c_PARAMS_OK = (FRAC_BITS < WIDTH) && (NUM_REQ >= 2) && (NUM_REQ <= 16);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic           neg;
        logic           zero;
    } tag_t;

    logic [IDW-1:0]     r_ptr_q, w_ptr_d;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDW-1:0]     w_grant_id;
    logic [IDW-1:0]     w_idx;
    logic               w_hs;
    logic [WIDTH-1:0]   w_sel_a, w_sel_b;

    logic               r_mul_valid_q, w_mul_valid_d;
    logic [WIDTH-1:0]   r_mul_a_q, w_mul_a_d;
    logic [WIDTH-1:0]   r_mul_b_q, w_mul_b_d;

    tag_t               r_tag_q [MUL_LATENCY+1];
    tag_t               w_tag_d [MUL_LATENCY+1];
    tag_t               w_tag_out;
    logic               w_rsp_fire;

    logic [NUM_REQ-1:0] r_rsp_valid_q, w_rsp_valid_d;
    logic [WIDTH-1:0]   r_rsp_data_q, w_rsp_data_d;
    logic               r_rsp_ovf_q, w_rsp_ovf_d;
    logic [c_CNT_W-1:0] r_cnt_q, w_cnt_d;

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        w_grant    = '0;
        w_grant_id = '0;
        w_hs       = 1'b0;
        w_idx      = '0;
        if (ENABLE && !RST) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_idx = IDW'((int'(r_ptr_q) + k) % NUM_REQ);
                if (!w_hs && REQ_VALID[w_idx]) begin
                    w_hs       = 1'b1;
                    w_grant_id = w_idx;
                end
            end
        end
        if (w_hs) begin
            w_grant[w_grant_id] = 1'b1;
        end
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a = REQ_A[i*WIDTH +: WIDTH];
                w_sel_b = REQ_B[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_tag_out  = r_tag_q[MUL_LATENCY];
    assign w_rsp_fire = MUL_RESULT_VALID && w_tag_out.valid;

    always_comb begin
        w_ptr_d       = r_ptr_q;
        w_mul_valid_d = w_hs;
        w_mul_a_d     = r_mul_a_q;
        w_mul_b_d     = r_mul_b_q;
        if (w_hs) begin
            w_ptr_d   = (w_grant_id == IDW'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
            w_mul_a_d = w_sel_a;
            w_mul_b_d = w_sel_b;
        end

        // Stage 0 lines up with MUL_VALID; the last stage with MUL_RESULT_VALID.
        w_tag_d[0].valid = w_hs;
        w_tag_d[0].id    = w_grant_id;
        w_tag_d[0].neg   = w_sel_a[WIDTH-1] ^ w_sel_b[WIDTH-1];
        w_tag_d[0].zero  = (w_sel_a == '0) || (w_sel_b == '0);
        for (int s = 1; s <= MUL_LATENCY; s++) begin
            w_tag_d[s] = r_tag_q[s-1];
        end

        w_rsp_valid_d = '0;
        w_rsp_data_d  = r_rsp_data_q;
        w_rsp_ovf_d   = r_rsp_ovf_q;
        if (w_rsp_fire) begin
            w_rsp_valid_d[w_tag_out.id] = 1'b1;
            w_rsp_data_d                = MUL_RESULT;
            w_rsp_ovf_d                 = !w_tag_out.zero && (MUL_RESULT[WIDTH-1] != w_tag_out.neg);
        end

        // A transaction stays counted through the cycle its response is presented.
        w_cnt_d = r_cnt_q;
        case ({w_hs, |r_rsp_valid_q})
            2'b10:   w_cnt_d = r_cnt_q + 1'b1;
            2'b01:   w_cnt_d = r_cnt_q - 1'b1;
            default: w_cnt_d = r_cnt_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr_q       <= '0;
            r_mul_valid_q <= 1'b0;
            r_mul_a_q     <= '0;
            r_mul_b_q     <= '0;
            for (int s = 0; s <= MUL_LATENCY; s++) begin
                r_tag_q[s] <= '0;
            end
            r_rsp_valid_q <= '0;
            r_rsp_data_q  <= '0;
            r_rsp_ovf_q   <= 1'b0;
            r_cnt_q       <= '0;
        end else begin
            r_ptr_q       <= w_ptr_d;
            r_mul_valid_q <= w_mul_valid_d;
            r_mul_a_q     <= w_mul_a_d;
            r_mul_b_q     <= w_mul_b_d;
            r_tag_q       <= w_tag_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_data_q  <= w_rsp_data_d;
            r_rsp_ovf_q   <= w_rsp_ovf_d;
            r_cnt_q       <= w_cnt_d;
        end
    end

    assign REQ_READY    = w_grant;
    assign MUL_VALID    = r_mul_valid_q;
    assign MUL_A        = r_mul_a_q;
    assign MUL_B        = r_mul_b_q;
    assign RSP_VALID    = r_rsp_valid_q;
    assign RSP_DATA     = r_rsp_data_q;
    assign RSP_OVERFLOW = r_rsp_ovf_q;
    assign IDLE         = (r_cnt_q == '0) && !w_hs;

    // Static guard on the parameter set; never toggles at run time.
    assert property (@(posedge CLK) c_PARAMS_OK);

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixed_point_mul_arbiter
// Brief    : Directed and random traffic against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_fixed_point_mul_arbiter;

    localparam int W   = 8;
    localparam int FB  = 3;
    localparam int NR  = 4;
    localparam int LAT = 1;

    logic            clk = 1'b0;
    logic            rst, en;
    logic [NR-1:0]   req_valid, req_ready, rsp_valid;
    logic [NR*W-1:0] req_a, req_b;
    logic [W-1:0]    mul_a, mul_b, mul_res, rsp_data;
    logic            mul_valid, mul_res_valid, rsp_ovf, idle;

    always #5 clk = ~clk;

    fixed_point_mul_arbiter #(
        .WIDTH(W), .FRAC_BITS(FB), .NUM_REQ(NR), .MUL_LATENCY(LAT)
    ) u_dut (
        .CLK(clk), .RST(rst), .ENABLE(en),
        .REQ_VALID(req_valid), .REQ_A(req_a), .REQ_B(req_b), .REQ_READY(req_ready),
        .MUL_A(mul_a), .MUL_B(mul_b), .MUL_VALID(mul_valid),
        .MUL_RESULT(mul_res), .MUL_RESULT_VALID(mul_res_valid),
        .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data), .RSP_OVERFLOW(rsp_ovf), .IDLE(idle)
    );

    function automatic logic [W-1:0] fx_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        p = p >>> FB;
        return W'(p);
    endfunction

    // Single-cycle multiplier, reset together with the arbiter.
    always @(posedge clk) begin
        if (rst) begin
            mul_res_valid <= 1'b0;
            mul_res       <= '0;
        end else begin
            mul_res_valid <= mul_valid;
            mul_res       <= fx_mul(mul_a, mul_b);
        end
    end

    typedef struct {
        int           id;
        logic [W-1:0] d;
        logic         ovf;
        int           due;
    } txn_t;

    txn_t         q[$];
    int           ptr, cycle, resp_now;
    logic [NR-1:0] exp_rv;
    logic [W-1:0] exp_d, exp_ma, exp_mb;
    logic         exp_ovf, exp_mv;
    int           n_checks = 0;
    int           n_fail   = 0;
    int           grant_log[$];
    int           rsp_log[$];
    logic [W-1:0] last_d;
    logic         last_ovf;
    int           last_id;
    logic         obs_idle;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    function automatic int onehot_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic step();
        logic [NR-1:0] eg;
        int            gid;
        bit            hs, rst_s;
        logic [W-1:0]  a, b, d;
        txn_t          t;
        @(negedge clk);
        rst_s = rst;
        eg    = '0;
        gid   = -1;
        if (en && !rst) begin
            for (int k = 0; k < NR; k++) begin
                if (gid < 0 && req_valid[(ptr + k) % NR]) gid = (ptr + k) % NR;
            end
        end
        hs = (gid >= 0);
        if (hs) eg[gid] = 1'b1;
        chk_eq("req_ready", 32'(req_ready), 32'(eg));
        chk_eq("idle", 32'(idle), 32'((q.size() + resp_now == 0) && !hs));
        chk_eq("mul_valid", 32'(mul_valid), 32'(exp_mv));
        chk_eq("mul_a", 32'(mul_a), 32'(exp_ma));
        chk_eq("mul_b", 32'(mul_b), 32'(exp_mb));
        chk_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        chk_eq("rsp_data", 32'(rsp_data), 32'(exp_d));
        chk_eq("rsp_ovf", 32'(rsp_ovf), 32'(exp_ovf));
        obs_idle = idle;
        if (req_ready != '0) grant_log.push_back(onehot_idx(req_ready));
        if (rsp_valid != '0) begin
            last_id  = onehot_idx(rsp_valid);
            last_d   = rsp_data;
            last_ovf = rsp_ovf;
            rsp_log.push_back(last_id);
        end
        exp_mv = hs;
        if (hs) begin
            a = req_a[gid*W +: W];
            b = req_b[gid*W +: W];
            d = fx_mul(a, b);
            t.id  = gid;
            t.d   = d;
            t.ovf = (a != 0) && (b != 0) && (d[W-1] != (a[W-1] ^ b[W-1]));
            t.due = cycle + LAT + 2;
            q.push_back(t);
            ptr    = (gid + 1) % NR;
            exp_ma = a;
            exp_mb = b;
        end
        @(posedge clk);
        #1;
        cycle++;
        resp_now = 0;
        exp_rv   = '0;
        if (rst_s) begin
            q.delete();
            ptr     = 0;
            exp_d   = '0;
            exp_ovf = 1'b0;
            exp_mv  = 1'b0;
            exp_ma  = '0;
            exp_mb  = '0;
        end else if (q.size() > 0 && q[0].due == cycle) begin
            t = q.pop_front();
            exp_rv[t.id] = 1'b1;
            exp_d        = t.d;
            exp_ovf      = t.ovf;
            resp_now     = 1;
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
    endtask

    task automatic one_txn(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        set_req(id, a, b);
        req_valid     = '0;
        req_valid[id] = 1'b1;
        step();
        req_valid = '0;
        idle_steps(4);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        ptr = 0; cycle = 0; resp_now = 0;
        exp_rv = '0; exp_d = '0; exp_ovf = 1'b0; exp_mv = 1'b0; exp_ma = '0; exp_mb = '0;
        last_d = '0; last_ovf = 1'b0; last_id = -1; obs_idle = 1'b0;
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        en  = 1'b1;

        // Single request on lane 2: 1.5 * 2.0
        one_txn(2, 8'h0C, 8'h10);
        chk_eq("single_id", 32'(last_id), 32'd2);
        chk_eq("single_data", 32'(last_d), 32'h18);
        chk_eq("single_ovf", 32'(last_ovf), 32'd0);

        // Round-robin from pointer 0 with all lanes busy
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, W'(8 * (i + 1)), W'(8'h10 + i));
        grant_log.delete(); rsp_log.delete();
        req_valid = '1;
        idle_steps(8);
        req_valid = '0;
        idle_steps(4);
        chk_eq("rr_count", 32'(grant_log.size()), 32'd8);
        chk_eq("rr_rsp_count", 32'(rsp_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < grant_log.size()) chk_eq("rr_grant", 32'(grant_log[i]), 32'(i % NR));
            if (i < rsp_log.size()) chk_eq("rr_rsp", 32'(rsp_log[i]), 32'(i % NR));
        end

        // Sign and overflow corners
        one_txn(0, 8'hF4, 8'h10);
        chk_eq("neg_data", 32'(last_d), 32'hE8);
        chk_eq("neg_ovf", 32'(last_ovf), 32'd0);
        one_txn(0, 8'h40, 8'h10);
        chk_eq("ovf_data", 32'(last_d), 32'h80);
        chk_eq("ovf_flag", 32'(last_ovf), 32'd1);
        one_txn(0, 8'h00, 8'hF0);
        chk_eq("zero_data", 32'(last_d), 32'h00);
        chk_eq("zero_ovf", 32'(last_ovf), 32'd0);

        // Pointer at 3, lanes 1 and 3 valid: grant 3 then 1, pointer lands on 2
        one_txn(2, 8'h11, 8'h22);
        grant_log.delete();
        req_valid = 4'b1010;
        idle_steps(2);
        req_valid = '1;
        step();
        req_valid = '0;
        idle_steps(4);
        chk_eq("skip_count", 32'(grant_log.size()), 32'd3);
        if (grant_log.size() == 3) begin
            chk_eq("skip_g0", 32'(grant_log[0]), 32'd3);
            chk_eq("skip_g1", 32'(grant_log[1]), 32'd1);
            chk_eq("skip_g2", 32'(grant_log[2]), 32'd2);
        end

        // ENABLE drop with two transactions in flight
        grant_log.delete(); rsp_log.delete();
        req_valid = 4'b0011;
        idle_steps(2);
        en = 1'b0;
        idle_steps(5);
        chk_eq("dis_grants", 32'(grant_log.size()), 32'd2);
        chk_eq("dis_rsps", 32'(rsp_log.size()), 32'd2);
        chk_eq("dis_idle", 32'(obs_idle), 32'd1);
        en = 1'b1;
        step();
        req_valid = '0;
        idle_steps(4);
        if (grant_log.size() == 3) chk_eq("reen_grant", 32'(grant_log[2]), 32'd0);
        else chk_eq("reen_count", 32'(grant_log.size()), 32'd3);

        // Reset with two transactions in flight
        for (int i = 0; i < NR; i++) set_req(i, 8'h18, 8'h18);
        req_valid = '1;
        idle_steps(2);
        rsp_log.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 4'b0001;
        set_req(0, 8'h08, 8'h08);
        step();
        req_valid = '0;
        idle_steps(4);
        chk_eq("rst_rsp_count", 32'(rsp_log.size()), 32'd1);
        chk_eq("rst_data", 32'(last_d), 32'h08);
        chk_eq("rst_id", 32'(last_id), 32'd0);

        // Random traffic with occasional disable and reset
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 59) == 0);
            en        = ($urandom_range(0, 7) != 0);
            req_valid = NR'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            step();
        end
        rst = 1'b0;
        en  = 1'b1;
        req_valid = '0;
        idle_steps(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
